// File: rtl/ddr_burst_sched_pkg.sv
// Shared definitions for the DDR3 burst scheduler: FSM state encoding,
// last-served encoding and the burst-size helper used by both address
// generators.
package ddr_sched_pkg;

  localparam int BEAT_BYTES_LOG2_DEF = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4
  } state_t;

  typedef enum logic {
    SERVED_WR = 1'b0,
    SERVED_RD = 1'b1
  } served_t;

  // Bytes moved by one burst of (len+1) beats.
  function automatic logic [15:0] burst_bytes(input logic [7:0] len,
                                              input int unsigned beat_log2);
    return (16'(len) + 16'd1) << beat_log2;
  endfunction

endpackage

// File: rtl/ddr_burst_sched_if.sv
// Command/completion bus between the burst scheduler (master) and the AXI
// burst engine (slave). One write and one read command channel, each with
// a completion pulse.
interface ddr_burst_sched_if #(
  parameter int ADDR_W = 30
);

  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [7:0]        wr_cmd_len;
  logic              wr_done;

  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [7:0]        rd_cmd_len;
  logic              rd_done;

  modport master (
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    input  wr_cmd_ready, wr_done,
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  rd_cmd_ready, rd_done
  );

  modport slave (
    input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    output wr_cmd_ready, wr_done,
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output rd_cmd_ready, rd_done
  );

endinterface

// File: rtl/ddr_burst_sched_addr_wrap.sv
// Wrapping address generator for one DDR3 window. Holds the offset from the
// window start, captures address/length/window at issue and steps the
// offset on completion. A burst that would cross the window end is never
// produced: the offset returns to zero instead.
module ddr_addr_wrap
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_W          = 30,
  parameter int BEAT_BYTES_LOG2 = BEAT_BYTES_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] beg_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [7:0]        burst_len,
  input  logic              load,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        len
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] beg_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W+1:0] next_last;
  logic              wrap;

  // Step size comes from the length that was actually issued, and the wrap
  // test uses the window captured at issue, so config changes mid-burst
  // only affect the following burst. The compare is two bits wider so
  // windows near the top of the address space cannot overflow.
  assign bytes     = ADDR_W'(burst_bytes(len, BEAT_BYTES_LOG2));
  assign nxt       = off + bytes;
  assign next_last = {2'b00, beg_q} + {2'b00, off} + {2'b00, bytes}
                   + {2'b00, bytes} - (ADDR_W+2)'(1);
  assign wrap      = next_last > {2'b00, end_q};

  // Capture the command at issue, advance the offset at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off   <= '0;
      beg_q <= '0;
      end_q <= '0;
      addr  <= '0;
      len   <= '0;
    end else begin
      if (load) begin
        addr  <= beg_addr + off;
        len   <= burst_len;
        beg_q <= beg_addr;
        end_q <= end_addr;
      end
      if (advance) begin
        off <= wrap ? '0 : nxt;
      end
    end
  end

endmodule

// File: rtl/ddr_burst_sched.sv
// DDR3 burst scheduler. Decides when to drain the write FIFO or refill the
// read FIFO, arbitrates between the two, and keeps exactly one burst
// command outstanding toward the AXI burst engine.
// Optional build macro DDR_SCHED_WR_PRIO_EN: strict write priority instead
// of round-robin on ties.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_W          = 30,
  parameter int CNT_W           = 11,
  parameter int RD_FIFO_DEPTH   = 1024,
  parameter int BEAT_BYTES_LOG2 = BEAT_BYTES_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wr_beg_addr,
  input  logic [ADDR_W-1:0] wr_end_addr,
  input  logic [7:0]        wr_burst_len,
  input  logic [ADDR_W-1:0] rd_beg_addr,
  input  logic [ADDR_W-1:0] rd_end_addr,
  input  logic [7:0]        rd_burst_len,
  input  logic              rd_mem_enable,
  input  logic [CNT_W-1:0]  wr_fifo_cnt,
  input  logic [CNT_W-1:0]  rd_fifo_cnt,
  ddr_burst_sched_if.master bus,
  output logic              busy
);

  state_t  state;
  served_t last_served;
  logic    wr_valid;
  logic    rd_valid;

  logic [CNT_W:0] wr_need;
  logic [CNT_W:0] rd_need;
  logic [CNT_W:0] rd_room;
  logic           wr_ok;
  logic           rd_ok;
  logic           pick_wr;
  logic           pick_rd;
  logic           wr_load;
  logic           rd_load;
  logic           wr_adv;
  logic           rd_adv;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        wr_len;
  logic [7:0]        rd_len;

  // A write needs a whole burst waiting in the write FIFO; a read needs room
  // for a whole burst in the read FIFO.
  assign wr_need = (CNT_W+1)'(wr_burst_len) + (CNT_W+1)'(1);
  assign rd_need = (CNT_W+1)'(rd_burst_len) + (CNT_W+1)'(1);
  assign rd_room = (CNT_W+1)'(RD_FIFO_DEPTH) - {1'b0, rd_fifo_cnt};
  assign wr_ok   = {1'b0, wr_fifo_cnt} >= wr_need;
  assign rd_ok   = rd_mem_enable && (rd_room >= rd_need);

`ifdef DDR_SCHED_WR_PRIO_EN
  // Writes always win; reads only fill gaps when no write burst is ready.
  assign pick_wr = wr_ok;
`else
  // On a tie, serve whichever side did not go last.
  assign pick_wr = wr_ok && (!rd_ok || (last_served == SERVED_RD));
`endif
  assign pick_rd = rd_ok && !pick_wr;

  assign wr_load = (state == IDLE) && pick_wr;
  assign rd_load = (state == IDLE) && pick_rd;

  // Completion is honoured in WAIT, or in REQ when it lands on the handshake
  // cycle itself; stray pulses in any other state are dropped.
  assign wr_adv = bus.wr_done &&
                  ((state == WR_WAIT) || ((state == WR_REQ) && bus.wr_cmd_ready));
  assign rd_adv = bus.rd_done &&
                  ((state == RD_WAIT) || ((state == RD_REQ) && bus.rd_cmd_ready));

  // Issue / handshake / completion sequencing with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= SERVED_RD;
      wr_valid    <= 1'b0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_wr) begin
            wr_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= WR_REQ;
          end else if (pick_rd) begin
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (wr_valid && bus.wr_cmd_ready) begin
            wr_valid <= 1'b0;
            if (bus.wr_done) begin
              last_served <= SERVED_WR;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (bus.wr_done) begin
            last_served <= SERVED_WR;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        RD_REQ: begin
          if (rd_valid && bus.rd_cmd_ready) begin
            rd_valid <= 1'b0;
            if (bus.rd_done) begin
              last_served <= SERVED_RD;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (bus.rd_done) begin
            last_served <= SERVED_RD;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          wr_valid <= 1'b0;
          rd_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  ddr_addr_wrap #(
    .ADDR_W          (ADDR_W),
    .BEAT_BYTES_LOG2 (BEAT_BYTES_LOG2)
  ) u_wr_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .beg_addr  (wr_beg_addr),
    .end_addr  (wr_end_addr),
    .burst_len (wr_burst_len),
    .load      (wr_load),
    .advance   (wr_adv),
    .addr      (wr_addr),
    .len       (wr_len)
  );

  ddr_addr_wrap #(
    .ADDR_W          (ADDR_W),
    .BEAT_BYTES_LOG2 (BEAT_BYTES_LOG2)
  ) u_rd_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .beg_addr  (rd_beg_addr),
    .end_addr  (rd_end_addr),
    .burst_len (rd_burst_len),
    .load      (rd_load),
    .advance   (rd_adv),
    .addr      (rd_addr),
    .len       (rd_len)
  );

  assign bus.wr_cmd_valid = wr_valid;
  assign bus.wr_cmd_addr  = wr_addr;
  assign bus.wr_cmd_len   = wr_len;
  assign bus.rd_cmd_valid = rd_valid;
  assign bus.rd_cmd_addr  = rd_addr;
  assign bus.rd_cmd_len   = rd_len;

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Directed bench for ddr_burst_sched. A window/burst-count model predicts
// every command address; a monitor matches each new command against the
// expected queue and checks stability and mutual exclusion every cycle.
module tb_ddr_burst_sched;

  localparam int ADDR_W  = 30;
  localparam int CNT_W   = 11;
  localparam int DEPTH   = 1024;
  localparam int NO_DONE = -2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] wr_beg_addr = '0;
  logic [ADDR_W-1:0] wr_end_addr = '0;
  logic [7:0]        wr_burst_len = '0;
  logic [ADDR_W-1:0] rd_beg_addr = '0;
  logic [ADDR_W-1:0] rd_end_addr = '0;
  logic [7:0]        rd_burst_len = '0;
  logic              rd_mem_enable = 1'b0;
  logic [CNT_W-1:0]  wr_fifo_cnt = '0;
  logic [CNT_W-1:0]  rd_fifo_cnt = '0;
  logic              busy;

  ddr_burst_sched_if #(.ADDR_W(ADDR_W)) bus ();

  ddr_burst_sched #(
    .ADDR_W        (ADDR_W),
    .CNT_W         (CNT_W),
    .RD_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_beg_addr   (wr_beg_addr),
    .wr_end_addr   (wr_end_addr),
    .wr_burst_len  (wr_burst_len),
    .rd_beg_addr   (rd_beg_addr),
    .rd_end_addr   (rd_end_addr),
    .rd_burst_len  (rd_burst_len),
    .rd_mem_enable (rd_mem_enable),
    .wr_fifo_cnt   (wr_fifo_cnt),
    .rd_fifo_cnt   (rd_fifo_cnt),
    .bus           (bus),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } cmd_t;

  cmd_t exp_q[$];
  int   wr_k = 0;
  int   rd_k = 0;

  // k-th burst address in a window: only whole bursts fit, then it wraps.
  function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] beg,
                                                   input logic [ADDR_W-1:0] last,
                                                   input logic [7:0] len, input int k);
    longint bytes;
    longint span;
    longint n;
    bytes = (longint'(len) + 1) * 8;
    span  = longint'(last) - longint'(beg) + 1;
    n     = (span > 0) ? span / bytes : 0;
    if (n == 0) return beg;
    return beg + ADDR_W'((longint'(k) % n) * bytes);
  endfunction

  task automatic expect_wr();
    exp_q.push_back('{wr: 1'b1, addr: model_addr(wr_beg_addr, wr_end_addr, wr_burst_len, wr_k),
                      len: wr_burst_len});
    wr_k++;
  endtask

  task automatic expect_rd();
    exp_q.push_back('{wr: 1'b0, addr: model_addr(rd_beg_addr, rd_end_addr, rd_burst_len, rd_k),
                      len: rd_burst_len});
    rd_k++;
  endtask

  task automatic match_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    cmd_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_cmd: got wr=%0d addr 0x%0h, required no command", wr, a);
      return;
    end
    e = exp_q.pop_front();
    check("cmd_kind", 64'(wr), 64'(e.wr));
    check("cmd_addr", 64'(a), 64'(e.addr));
    check("cmd_len", 64'(l), 64'(e.len));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic              pw;
    logic              pr;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    logic [7:0]        wl;
    logic [7:0]        rl;
    pw = 1'b0;
    pr = 1'b0;
    wa = '0;
    ra = '0;
    wl = '0;
    rl = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pw = 1'b0;
        pr = 1'b0;
      end else begin
        check("single_outstanding", 64'(bus.wr_cmd_valid && bus.rd_cmd_valid), 64'd0);
        if (bus.wr_cmd_valid) begin
          if (!pw) begin
            match_cmd(1'b1, bus.wr_cmd_addr, bus.wr_cmd_len);
            wa = bus.wr_cmd_addr;
            wl = bus.wr_cmd_len;
          end else begin
            check("wr_addr_stable", 64'(bus.wr_cmd_addr), 64'(wa));
            check("wr_len_stable", 64'(bus.wr_cmd_len), 64'(wl));
          end
          check("busy_with_wr", 64'(busy), 64'd1);
        end
        if (bus.rd_cmd_valid) begin
          if (!pr) begin
            match_cmd(1'b0, bus.rd_cmd_addr, bus.rd_cmd_len);
            ra = bus.rd_cmd_addr;
            rl = bus.rd_cmd_len;
          end else begin
            check("rd_addr_stable", 64'(bus.rd_cmd_addr), 64'(ra));
            check("rd_len_stable", 64'(bus.rd_cmd_len), 64'(rl));
          end
          check("busy_with_rd", 64'(busy), 64'd1);
        end
        pw = bus.wr_cmd_valid;
        pr = bus.rd_cmd_valid;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.wr_cmd_ready = 1'b0;
    bus.rd_cmd_ready = 1'b0;
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
    wr_beg_addr = '0;
    wr_end_addr = '0;
    wr_burst_len = '0;
    rd_beg_addr = '0;
    rd_end_addr = '0;
    rd_burst_len = '0;
    rd_mem_enable = 1'b0;
    wr_fifo_cnt = '0;
    rd_fifo_cnt = '0;
    exp_q.delete();
    wr_k = 0;
    rd_k = 0;
    repeat (2) @(negedge clk);
    check("rst_wr_valid", 64'(bus.wr_cmd_valid), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_cmd_valid), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_cmd_addr), 64'd0);
    check("rst_rd_len", 64'(bus.rd_cmd_len), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
  endtask

  // Wait for a command, optionally stall ready, handshake, then complete:
  // dly >= 0 gives done dly cycles after the handshake, -1 gives done on
  // the handshake cycle, NO_DONE leaves the burst open.
  task automatic serve(input int stall, input int dly,
                       output logic wr, output logic [ADDR_W-1:0] a);
    int t;
    t = 0;
    wr = 1'b0;
    a = '0;
    while (!bus.wr_cmd_valid && !bus.rd_cmd_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_timeout: got no command in 200 cycles, required one");
      return;
    end
    wr = bus.wr_cmd_valid;
    a  = wr ? bus.wr_cmd_addr : bus.rd_cmd_addr;
    repeat (stall) @(negedge clk);
    if (stall > 0)
      check("stall_valid_held", 64'(wr ? bus.wr_cmd_valid : bus.rd_cmd_valid), 64'd1);
    if (wr) bus.wr_cmd_ready = 1'b1;
    else    bus.rd_cmd_ready = 1'b1;
    if (dly == -1) begin
      if (wr) bus.wr_done = 1'b1;
      else    bus.rd_done = 1'b1;
    end
    @(negedge clk);
    bus.wr_cmd_ready = 1'b0;
    bus.rd_cmd_ready = 1'b0;
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
    check("valid_drop", 64'(wr ? bus.wr_cmd_valid : bus.rd_cmd_valid), 64'd0);
    if (dly >= 0) begin
      repeat (dly) @(negedge clk);
      if (wr) bus.wr_done = 1'b1;
      else    bus.rd_done = 1'b1;
      @(negedge clk);
      bus.wr_done = 1'b0;
      bus.rd_done = 1'b0;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic              k;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] wrap_exp [5];
    logic [3:0]        order;
    wrap_exp = '{30'h1000, 30'h1200, 30'h1400, 30'h1600, 30'h1000};
`ifdef DDR_SCHED_WR_PRIO_EN
    order = 4'b1111;
`else
    order = 4'b1010;
`endif
    bus.wr_cmd_ready = 1'b0;
    bus.rd_cmd_ready = 1'b0;
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;

    // Single write, then the next one 0x200 further on.
    apply_reset();
    wr_end_addr = 30'h000F_FFFF;
    wr_burst_len = 8'd63;
    expect_wr();
    expect_wr();
    wr_fifo_cnt = 11'd64;
    serve(0, 2, k, a);
    check("single_kind", 64'(k), 64'd1);
    check("single_addr0", 64'(a), 64'h0);
    check("single_len", 64'(bus.wr_cmd_len), 64'd63);
    serve(0, -1, k, a);
    wr_fifo_cnt = '0;
    check("single_addr1", 64'(a), 64'h200);

    // Wrap inside 0x1000..0x17FF.
    apply_reset();
    wr_beg_addr = 30'h1000;
    wr_end_addr = 30'h17FF;
    wr_burst_len = 8'd63;
    for (int i = 0; i < 5; i++) expect_wr();
    wr_fifo_cnt = 11'd64;
    for (int i = 0; i < 5; i++) begin
      serve(0, (i % 2 == 1) ? -1 : 1, k, a);
      check("wrap_addr", 64'(a), 64'(wrap_exp[i]));
    end
    wr_fifo_cnt = '0;

    // Both sides eligible: arbitration order.
    apply_reset();
    wr_end_addr = 30'h0000_FFFF;
    wr_burst_len = 8'd63;
    rd_beg_addr = 30'h2_0000;
    rd_end_addr = 30'h2_FFFF;
    rd_burst_len = 8'd63;
    for (int i = 0; i < 4; i++) begin
      if (order[3-i]) expect_wr();
      else            expect_rd();
    end
    rd_mem_enable = 1'b1;
    wr_fifo_cnt = 11'd64;
    for (int i = 0; i < 4; i++) begin
      serve(0, 1, k, a);
      check("tie_kind", 64'(k), 64'(order[3-i]));
    end
    wr_fifo_cnt = '0;
    rd_mem_enable = 1'b0;

    // Read gating on enable and free space; stray completions are ignored.
    apply_reset();
    rd_beg_addr = 30'h3_0000;
    rd_end_addr = 30'h3_FFFF;
    rd_burst_len = 8'd63;
    bus.wr_done = 1'b1;
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
    repeat (20) @(negedge clk);
    check("gate_disabled_valid", 64'(bus.rd_cmd_valid), 64'd0);
    check("gate_disabled_busy", 64'(busy), 64'd0);
    rd_mem_enable = 1'b1;
    rd_fifo_cnt = 11'd961;
    repeat (20) @(negedge clk);
    check("gate_961_valid", 64'(bus.rd_cmd_valid), 64'd0);
    expect_rd();
    rd_fifo_cnt = 11'd960;
    serve(0, 0, k, a);
    rd_mem_enable = 1'b0;
    check("gate_960_kind", 64'(k), 64'd0);
    check("gate_960_addr", 64'(a), 64'h3_0000);

    // Ready stalled 10 cycles; then a window smaller than one burst.
    apply_reset();
    wr_end_addr = 30'h0000_FFFF;
    wr_burst_len = 8'd15;
    expect_wr();
    wr_fifo_cnt = 11'd16;
    serve(10, 1, k, a);
    wr_fifo_cnt = '0;
    check("stall_addr", 64'(a), 64'h0);
    apply_reset();
    wr_beg_addr = 30'h500;
    wr_end_addr = 30'h5FF;
    wr_burst_len = 8'd63;
    expect_wr();
    expect_wr();
    wr_fifo_cnt = 11'd64;
    serve(0, 0, k, a);
    check("small_win_addr0", 64'(a), 64'h500);
    serve(0, 0, k, a);
    wr_fifo_cnt = '0;
    check("small_win_addr1", 64'(a), 64'h500);

    // Reset while a read burst is waiting for completion.
    apply_reset();
    rd_beg_addr = 30'h4_0000;
    rd_end_addr = 30'h4_FFFF;
    rd_burst_len = 8'd31;
    expect_rd();
    expect_rd();
    rd_mem_enable = 1'b1;
    serve(0, 0, k, a);
    check("mid_rst_addr0", 64'(a), 64'h4_0000);
    serve(0, NO_DONE, k, a);
    check("mid_rst_addr1", 64'(a), 64'h4_0100);
    check("rd_wait_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_valid", 64'(bus.rd_cmd_valid), 64'd0);
    check("async_rst_wr_valid", 64'(bus.wr_cmd_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_rd_addr", 64'(bus.rd_cmd_addr), 64'd0);
    check("async_rst_rd_len", 64'(bus.rd_cmd_len), 64'd0);
    exp_q.delete();
    rd_k = 0;
    expect_rd();
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 0, k, a);
    rd_mem_enable = 1'b0;
    check("post_rst_addr", 64'(a), 64'h4_0000);

    repeat (5) @(negedge clk);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr_burst_sched.md
Name: ddr_burst_sched

Overview:
- Burst scheduler between the user-side write/read FIFOs and the AXI burst master of the DDR3 path. Runs on the MIG user clock.
- Decides when a write burst (drain write FIFO to DDR3) or a read burst (refill read FIFO from DDR3) is issued, and arbitrates between them.
- Generates the wrapping 30-bit byte addresses inside the configured write and read windows.
- Hands one burst command at a time to the AXI master and waits for that burst's completion before issuing the next.

Parameters:
- ADDR_W, 30, AXI byte-address width.
- CNT_W, 11, width of the FIFO fill-level inputs (64-bit words).
- RD_FIFO_DEPTH, 1024, read-FIFO capacity in 64-bit words.
- BEAT_BYTES_LOG2, 3, log2 of the bytes per AXI beat (64-bit data).

Ports:
- clk  in  1  scheduler clock (ui_clk).
- rst_n  in  1  asynchronous active-low reset.
- wr_beg_addr  in  ADDR_W  write window start address (byte).
- wr_end_addr  in  ADDR_W  write window last address (byte, inclusive).
- wr_burst_len  in  8  AXI awlen (beats-1).
- rd_beg_addr  in  ADDR_W  read window start address.
- rd_end_addr  in  ADDR_W  read window last address (inclusive).
- rd_burst_len  in  8  AXI arlen (beats-1).
- rd_mem_enable  in  1  read bursts permitted.
- wr_fifo_cnt  in  CNT_W  words available in the write FIFO (read side).
- rd_fifo_cnt  in  CNT_W  words held in the read FIFO (write side).
- wr_cmd_valid  out  1  write burst command valid.
- wr_cmd_ready  in  1  AXI master accepts the write command.
- wr_cmd_addr  out  ADDR_W  write burst address.
- wr_cmd_len  out  8  write burst length.
- wr_done  in  1  one-cycle pulse at the write response (bvalid&bready).
- rd_cmd_valid  out  1  read burst command valid.
- rd_cmd_ready  in  1  AXI master accepts the read command.
- rd_cmd_addr  out  ADDR_W  read burst address.
- rd_cmd_len  out  8  read burst length.
- rd_done  in  1  one-cycle pulse at the last read beat (rlast&rvalid&rready).
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: wr_cmd_valid=0, rd_cmd_valid=0, cmd addr/len=0, busy=0, offsets=0, last_served=RD (so a write wins the first tie), state=IDLE.
- Address offsets: wr_off and rd_off are relative to their window's beg address. Command address = beg + off, registered at issue.
- Burst bytes = (len+1) << BEAT_BYTES_LOG2.
- Eligibility:
  - wr_ok = wr_fifo_cnt >= wr_burst_len+1.
  - rd_ok = rd_mem_enable && (RD_FIFO_DEPTH - rd_fifo_cnt) >= rd_burst_len+1.
  - All comparisons use CNT_W+1-bit unsigned arithmetic.
- States:
  - IDLE:
    - Both eligible: serve the opposite of last_served.
    - Only one eligible: serve it.
    - Serving loads cmd addr/len and sets the valid, then goes to WR_REQ or RD_REQ.
    - Neither eligible: stay in IDLE.
  - WR_REQ / RD_REQ: valid held, and addr/len held stable, until valid&ready. Drop valid the cycle after the handshake and go to WR_WAIT / RD_WAIT.
  - WR_WAIT / RD_WAIT: wait for wr_done / rd_done.
    - On done: advance the offset, update last_served, return to IDLE. The next issue is possible 1 cycle later.
    - A done arriving in REQ in the same cycle as the handshake is also accepted: go straight to IDLE.
- Offset wrap:
  - nxt = off + burst_bytes.
  - If beg + nxt + burst_bytes - 1 > end_addr, then off <= 0, else off <= nxt.
  - A partial burst past end_addr is never issued.
  - If the window is smaller than one burst, the address stays at beg.
- Config inputs are sampled only at issue. Changing them mid-burst affects the next burst only.
- rd_mem_enable falling during RD_REQ/RD_WAIT does not abort the burst.
- wr_done/rd_done pulses in non-matching states are ignored.
- Reset asserted mid-burst returns everything to reset values immediately. The upstream master is reset by the same signal.
- Only one command is outstanding at a time: wr_cmd_valid and rd_cmd_valid are never both high.

Optional Feature:
- Macro DDR_SCHED_WR_PRIO_EN.
- Defined: strict write priority. In IDLE, a write is chosen whenever wr_ok, regardless of last_served; reads are served only when wr_ok=0.
- Undefined: round-robin on ties as described above.

Decomposition:
- Shared package ddr_sched_pkg holds:
  - state enum (IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT);
  - BEAT_BYTES_LOG2 default;
  - WR/RD last-served encoding.
- One sub-module, ddr_addr_wrap, is instantiated twice (write and read). It holds the offset register and the wrap compare, with an advance strobe in and addr out.

Test Plan:
- Single write: wr_fifo_cnt=64, wr_burst_len=63, beg=0 → wr_cmd_addr=0, len=63. After wr_done, the next write address is 0x200.
- Wrap: beg=0x1000, end=0x17FF, len=63 → addresses 0x1000, 0x1200, 0x1400, 0x1600, then 0x1000.
- Tie round-robin: wr_ok and rd_ok held high → issue order W, R, W, R. With DDR_SCHED_WR_PRIO_EN defined → W, W, W, ...
- Read gating: rd_mem_enable=0 with an empty read FIFO → no rd_cmd_valid. With rd_mem_enable=1 and rd_fifo_cnt=961 (DEPTH 1024, len 63) → no read; with rd_fifo_cnt=960 → read issued.
- Handshake stall: wr_cmd_ready held low for 10 cycles → valid, addr and len stay stable and no second command appears. Ready high for 1 cycle → valid drops the next cycle.
- Reset mid-burst: assert rst_n=0 in RD_WAIT → all outputs 0 asynchronously. After release, the first read address is rd_beg_addr.
